// File: rtl/vp_recovery_ctrl.sv
// Speculation-recovery controller: logs overwritten registers while a value
// prediction is outstanding and replays them newest-first on a misprediction.
module vp_recovery_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOG_DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      vp_issue,
  input  logic [ADDR_WIDTH-1:0]     vp_pc,
  input  logic                      vp_done,
  input  logic                      vp_recover,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_reg,
  input  logic [DATA_WIDTH-1:0]     wb_old_data,
  output logic                      recover_en,
  output logic                      spec_stall,
  output logic                      flush,
  output logic                      rf_restore_valid,
  output logic [REG_ADDR_WIDTH-1:0] rf_restore_reg,
  output logic [DATA_WIDTH-1:0]     rf_restore_data,
  output logic                      redirect_valid,
  output logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic                      recovery_done
);

  localparam int IW = $clog2(LOG_DEPTH);
  localparam int CW = IW + 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SPEC     = 2'd1;
  localparam logic [1:0] S_RESTORE  = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  localparam logic [CW-1:0] FULL  = CW'(LOG_DEPTH);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [IW-1:0] ONE_I = IW'(1);

  logic [1:0]                state;
  logic [CW-1:0]             count;
  logic [REG_ADDR_WIDTH-1:0] log_reg  [LOG_DEPTH];
  logic [DATA_WIDTH-1:0]     log_data [LOG_DEPTH];

  logic          push;
  logic [CW-1:0] count_after_push;
  logic [IW-1:0] rd_idx;

  // A write-back that commits with vp_done is architectural, so it is not logged.
  assign push = (state == S_SPEC) && wb_valid && (wb_reg != '0) && (count < FULL) &&
                !(vp_done && !vp_recover);
  assign count_after_push = push ? count + ONE_C : count;
  assign rd_idx = count[IW-1:0] - ONE_I;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      redirect_pc <= '0;
      flush       <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state)
        S_IDLE: begin
          if (vp_issue) begin
            redirect_pc <= vp_pc;
            count       <= '0;
            state       <= S_SPEC;
          end
        end
        S_SPEC: begin
          if (vp_recover) begin
            flush <= 1'b1;
            count <= count_after_push;
            state <= (count_after_push != '0) ? S_RESTORE : S_REDIRECT;
          end else if (vp_done) begin
            count <= '0;
            state <= S_IDLE;
          end else begin
            count <= count_after_push;
          end
        end
        S_RESTORE: begin
          count <= count - ONE_C;
          if (count == ONE_C) state <= S_REDIRECT;
        end
        S_REDIRECT: state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      log_reg[count[IW-1:0]]  <= wb_reg;
      log_data[count[IW-1:0]] <= wb_old_data;
    end
  end

  assign recover_en       = (state == S_SPEC);
  assign spec_stall       = (state == S_SPEC) && (count == FULL);
  assign rf_restore_valid = (state == S_RESTORE);
  assign rf_restore_reg   = rf_restore_valid ? log_reg[rd_idx]  : '0;
  assign rf_restore_data  = rf_restore_valid ? log_data[rd_idx] : '0;
  assign redirect_valid   = (state == S_REDIRECT);
  assign recovery_done    = (state == S_REDIRECT);

endmodule

// File: doc/vp_recovery_ctrl.md
# vp_recovery_ctrl

Speculation-recovery controller paired with the load value predictor. It opens a speculation window when the predictor issues a predicted load value and logs the old value of every register overwritten during that window in an undo log. It grants the predictor permission to validate (`recover_en`). On a misprediction it flushes, restores the logged registers newest-first through the register file restore port, redirects fetch to the predicted load's PC, and pulses `recovery_done`. It sits between the value predictor, the register file write-back path and the fetch/hazard unit.

## Interface
- `DATA_WIDTH`, 32, register data width
- `ADDR_WIDTH`, 32, PC width
- `REG_ADDR_WIDTH`, 5, register index width
- `LOG_DEPTH`, 8, undo-log entries (power of two, ≥2)

- `clk` in 1 — single clock
- `rst_n` in 1 — asynchronous, active-low reset
- `vp_issue` in 1 — predictor issued a prediction this cycle
- `vp_pc` in ADDR_WIDTH — PC of the predicted load, valid with `vp_issue`
- `vp_done` in 1 — prediction confirmed correct
- `vp_recover` in 1 — misprediction detected
- `wb_valid` in 1 — register write-back this cycle
- `wb_reg` in REG_ADDR_WIDTH — destination register
- `wb_old_data` in DATA_WIDTH — value of `wb_reg` before this write
- `recover_en` out 1 — speculation window open; predictor may validate
- `spec_stall` out 1 — undo log full; upstream must hold write-back
- `flush` out 1 — one-cycle pipeline flush
- `rf_restore_valid` out 1, `rf_restore_reg` out REG_ADDR_WIDTH, `rf_restore_data` out DATA_WIDTH — register restore write
- `redirect_valid` out 1, `redirect_pc` out ADDR_WIDTH — fetch redirect
- `recovery_done` out 1 — one-cycle pulse; recovery complete

## Operation
- States: IDLE, SPEC, RESTORE, REDIRECT. Undo log is a LIFO of {reg, old_data} with `count` 0..LOG_DEPTH.
- IDLE: `vp_issue` → capture `vp_pc` into `redirect_pc`, set `count`=0, go to SPEC. Write-backs are not logged.
- SPEC: `recover_en`=1.
  - `wb_valid` && `wb_reg`≠0 && `count`<LOG_DEPTH → push the entry. Writes to r0 are never logged.
  - `spec_stall` = (SPEC && `count`==LOG_DEPTH), combinational. A write arriving while stalled is a protocol violation and is dropped.
  - `vp_issue` in SPEC is ignored; `redirect_pc` is unchanged.
- SPEC + `vp_done` (no `vp_recover`) → IDLE, `count`=0. A write-back in the same cycle is committed and not logged.
- SPEC + `vp_recover` → a same-cycle write-back is logged first. Then go to RESTORE if the resulting `count`>0, else REDIRECT.
- `vp_recover` and `vp_done` in the same cycle: recover wins.
- `vp_done`/`vp_recover` outside SPEC are ignored.
- RESTORE:
  - `rf_restore_valid`=1, `rf_restore_reg`/`rf_restore_data` = entry `count`-1 (combinational from the log).
  - `count` decrements each cycle. When popping the last entry (`count`==1) → REDIRECT.
  - `wb_valid` is ignored.
- REDIRECT: `redirect_valid`=1 and `recovery_done`=1 for exactly one cycle, then IDLE.
- `flush` is registered: high exactly in the first cycle after `vp_recover` is accepted.

## Timing
- Reset: state IDLE, `count`=0, `redirect_pc`=0. All single-bit outputs are 0 and restore/redirect buses are 0 during and immediately after reset.
- Reset mid-RESTORE or mid-REDIRECT: abandon immediately. No further restore writes and no `recovery_done`.
- Issue at edge k → `recover_en` high from cycle k+1.
- Recover sampled at edge k with N logged entries (N≥1):
  - restore writes occur in cycles k+1..k+N;
  - `redirect_valid`/`recovery_done` occur in cycle k+N+1;
  - `flush` is high in cycle k+1.
- Recover with N=0: `flush`, `redirect_valid` and `recovery_done` all occur in cycle k+1.
- `recover_en` is low in RESTORE and REDIRECT.
- Restore order is strictly reverse of logging order. Duplicate registers are all restored, so the oldest value ends up in the register.

## Test plan
- Correct prediction:
  - issue with `vp_pc`=0x0040_0010;
  - write r3 (old 0x11) and r4 (old 0x22);
  - `vp_done` → IDLE next cycle, no restore or flush, `recover_en` drops.
- Misprediction:
  - issue with pc 0x0040_0020;
  - write r5 (old 0xAA), r6 (old 0xBB), r5 (old 0xCC);
  - `vp_recover` at edge k →
    - `flush` at k+1;
    - restores (r5, 0xCC), (r6, 0xBB), (r5, 0xAA) at k+1..k+3;
    - `redirect_pc`=0x0040_0020 with `recovery_done` at k+4.
- Log full with LOG_DEPTH=8: 8 writes → `spec_stall`=1. `vp_recover` → exactly 8 restores, `spec_stall` low afterwards.
- Empty-log recover plus r0 write: a write to r0 is not logged; `vp_recover` → `flush`, `redirect_valid` and `recovery_done` all in the next cycle, with no restores.
- Simultaneous events:
  - `vp_recover`+`vp_done`+`wb_valid`(r7, old 0x77) in one cycle → recovery taken, first restore is (r7, 0x77);
  - `vp_issue` in SPEC does not change `redirect_pc`.
- Reset asserted at the second RESTORE cycle → all outputs 0 immediately, state IDLE, no `recovery_done`.
